// File: rtl/sap1_prog_loader_pkg.sv
// Shared definitions for the SAP-1 program loader: memory geometry and FSM state encoding.
package sap1_prog_loader_pkg;

  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned MEM_AW    = 4;
  localparam int unsigned MEM_DW    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    FAIL  = 3'd4
  } state_t;

endpackage

// File: rtl/sap1_prog_loader.sv
// Streams a program image into SAP-1 memory, verifies its checksum, and
// holds the CPU in clear until a good image has been loaded.
module sap1_prog_loader
  import sap1_prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH,
  parameter int unsigned AW    = MEM_AW,
  parameter int unsigned DW    = MEM_DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          cpu_clr,
  output logic          done,
  output logic          err,
  output logic [AW:0]   byte_cnt
);

  localparam int unsigned CW = AW + 1;

  state_t        state;
  state_t        state_d;
  logic [DW-1:0] sum;
  logic [DW-1:0] sum_d;
  logic [DW-1:0] check_sum;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          we_d;
  logic          ready_d;
  logic          cpu_clr_d;
  logic          done_d;
  logic          err_d;
  logic          xfer;

  // in_ready is registered from the next state, so it always equals a decode of state
  assign xfer      = in_valid && in_ready;
  assign check_sum = sum + in_data;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state;
    cnt_d   = byte_cnt;
    sum_d   = sum;
    addr_d  = ram_addr;
    wdata_d = ram_wdata;
    we_d    = 1'b0;

    case (state)
      IDLE, RUN, FAIL: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
          addr_d  = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          addr_d  = byte_cnt[AW-1:0];
          wdata_d = in_data;
          we_d    = 1'b1;
          sum_d   = check_sum;
          cnt_d   = byte_cnt + CW'(1);
          if (byte_cnt == CW'(DEPTH - 1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        // The checksum byte only decides the outcome; it is never written
        if (xfer) begin
          state_d = (check_sum == '0) ? RUN : FAIL;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d   = (state_d == LOAD) || (state_d == CHECK);
    cpu_clr_d = (state_d != RUN);
    done_d    = (state_d == RUN);
    err_d     = (state_d == FAIL);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      sum       <= '0;
      byte_cnt  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      in_ready  <= 1'b0;
      cpu_clr   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      sum       <= sum_d;
      byte_cnt  <= cnt_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      ram_we    <= we_d;
      in_ready  <= ready_d;
      cpu_clr   <= cpu_clr_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
